// File: rtl/mnist_pkg.sv
// mnist_pkg
// Shared types and constants for the MNIST int8 inference controller slice.
//   state_e    : controller FSM state encoding (4 bits)
//   OUT_DIM_DEF / HID_DIM_DEF : default layer widths
//   SHIFT_W, LOGIT_W, CYC_W, WDOG_W : datapath widths
//   CLASS_ERR  : class code reported when a layer times out
//   sat_inc    : saturating increment for the cycle counter
package mnist_pkg;

    localparam int OUT_DIM_DEF = 10;
    localparam int HID_DIM_DEF = 32;
    localparam int SHIFT_W     = 6;
    localparam int LOGIT_W     = 8;
    localparam int CYC_W       = 24;
    localparam int WDOG_W      = 16;

    localparam logic [3:0] CLASS_ERR = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FC1_GO   = 4'd1,
        S_FC1_WAIT = 4'd2,
        S_FC2_GO   = 4'd3,
        S_FC2_WAIT = 4'd4,
        S_ARG      = 4'd5,
        S_RESULT   = 4'd6
    } state_e;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mnist_infer_ctrl_argmax.sv
// mnist_argmax_seq
// Serial argmax over OUT_DIM signed logits read from a synchronous memory
// with one cycle of read latency.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse; the scan begins on the following cycle
//   done      : high on the last scan cycle (final compare happens at its edge)
//   addr      : registered read address, 0..OUT_DIM-1, holds at OUT_DIM-1
//   data      : read data, valid one cycle after addr
//   best_idx  : index of the running/final maximum (lowest index on ties)
//   best_val  : value of the running/final maximum
module mnist_argmax_seq
    import mnist_pkg::*;
#(
    parameter int OUT_DIM = OUT_DIM_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    output logic [$clog2(OUT_DIM)-1:0] addr,
    input  logic signed [LOGIT_W-1:0] data,
    output logic [$clog2(OUT_DIM)-1:0] best_idx,
    output logic signed [LOGIT_W-1:0] best_val
);

    localparam int IDX_W = $clog2(OUT_DIM);
    localparam int CNT_W = $clog2(OUT_DIM + 1);

    logic                      active_q;
    logic [CNT_W-1:0]          cyc_q;
    logic [IDX_W-1:0]          addr_q;
    logic [IDX_W-1:0]          best_idx_q;
    logic signed [LOGIT_W-1:0] best_val_q;

    // cyc_q counts scan cycles from 0; on cycle t>=1 the data bus carries
    // logit[t-1], so the scan needs OUT_DIM+1 cycles in total.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            cyc_q      <= '0;
            addr_q     <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            cyc_q    <= '0;
            addr_q   <= '0;
        end else if (active_q) begin
            if (cyc_q == CNT_W'(OUT_DIM)) begin
                active_q <= 1'b0;
            end else begin
                cyc_q <= cyc_q + 1'b1;
            end
            if (addr_q != IDX_W'(OUT_DIM - 1)) begin
                addr_q <= addr_q + 1'b1;
            end
            if (cyc_q == CNT_W'(1)) begin
                // First logit seeds the running best unconditionally.
                best_idx_q <= '0;
                best_val_q <= data;
            end else if (cyc_q != '0 && data > best_val_q) begin
                // Strictly greater keeps the lowest index on ties.
                best_idx_q <= IDX_W'(cyc_q - 1'b1);
                best_val_q <= data;
            end
        end
    end

    assign done     = active_q && (cyc_q == CNT_W'(OUT_DIM));
    assign addr     = addr_q;
    assign best_idx = best_idx_q;
    assign best_val = best_val_q;

endmodule

// File: rtl/mnist_infer_ctrl.sv
// mnist_infer_ctrl
// Inference sequencer: on accepting an image it pulses fc1, waits for its
// done, pulses fc2, waits for its done, scans the 10 logits for the argmax
// and holds the result on a valid/ready port.
// Optional feature macro: MNIST_CTRL_WDOG_EN enables a per-layer watchdog
// that aborts to an error result after WDOG_CYCLES cycles without done.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : image request handshake (ready only when idle)
//   cfg_shift1/cfg_shift2   : requant shifts, latched on accept
//   fc1_start/fc1_done/fc1_shift : fc1 engine control
//   fc2_start/fc2_done/fc2_shift : fc2 engine control
//   logit_addr / logit_data : logit memory read port (1-cycle latency)
//   res_valid / res_ready   : result handshake
//   res_class, res_score, res_err, res_cycles : result payload
//   busy                    : high whenever not idle
module mnist_infer_ctrl
    import mnist_pkg::*;
#(
    parameter int HID_DIM     = HID_DIM_DEF,
    parameter int OUT_DIM     = OUT_DIM_DEF,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SHIFT_W-1:0]          cfg_shift1,
    input  logic [SHIFT_W-1:0]          cfg_shift2,
    output logic                        fc1_start,
    input  logic                        fc1_done,
    output logic [SHIFT_W-1:0]          fc1_shift,
    output logic                        fc2_start,
    input  logic                        fc2_done,
    output logic [SHIFT_W-1:0]          fc2_shift,
    output logic [$clog2(OUT_DIM)-1:0]  logit_addr,
    input  logic signed [LOGIT_W-1:0]   logit_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [3:0]                  res_class,
    output logic signed [LOGIT_W-1:0]   res_score,
    output logic                        res_err,
    output logic [CYC_W-1:0]            res_cycles,
    output logic                        busy
);

    localparam int IDX_W = $clog2(OUT_DIM);

    state_e              state_q, state_d;
    logic [SHIFT_W-1:0]  shift1_q, shift1_d;
    logic [SHIFT_W-1:0]  shift2_q, shift2_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;

    logic                accept;
    logic                arg_start;
    logic                arg_done;
    logic [IDX_W-1:0]    best_idx;
    logic signed [LOGIT_W-1:0] best_val;
    logic                wdog_hit;

    // HID_DIM only documents the fc1 width; nothing here depends on it.
    logic [31:0] unused_hid;
    assign unused_hid = 32'(HID_DIM);

    assign accept    = in_valid && (state_q == S_IDLE);
    assign arg_start = (state_q == S_FC2_WAIT) && fc2_done;

`ifdef MNIST_CTRL_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;

    // Counter is zero in the GO states, so it starts at 0 on WAIT entry.
    assign wdog_hit = ({1'b0, wdog_q} + 17'd1) == 17'(WDOG_CYCLES);

    always_comb begin
        wdog_d = '0;
        err_d  = err_q;
        if (state_q == S_FC1_WAIT || state_q == S_FC2_WAIT) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (accept) begin
            err_d = 1'b0;
        end else if ((state_q == S_FC1_WAIT && !fc1_done && wdog_hit) ||
                     (state_q == S_FC2_WAIT && !fc2_done && wdog_hit)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign res_err = err_q;
`else
    logic [31:0] unused_wdog;
    assign unused_wdog = 32'(WDOG_CYCLES);
    assign wdog_hit    = 1'b0;
    assign res_err     = 1'b0;
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        shift1_d = shift1_q;
        shift2_d = shift2_q;
        cyc_d    = cyc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_FC1_GO;
                end
            end
            S_FC1_GO: begin
                state_d = S_FC1_WAIT;
            end
            S_FC1_WAIT: begin
                if (fc1_done) begin
                    state_d = S_FC2_GO;
                end else if (wdog_hit) begin
                    state_d = S_RESULT;
                end
            end
            S_FC2_GO: begin
                state_d = S_FC2_WAIT;
            end
            S_FC2_WAIT: begin
                if (fc2_done) begin
                    state_d = S_ARG;
                end else if (wdog_hit) begin
                    state_d = S_RESULT;
                end
            end
            S_ARG: begin
                if (arg_done) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            shift1_d = cfg_shift1;
            shift2_d = cfg_shift2;
            cyc_d    = '0;
        end else if (state_q != S_IDLE && state_q != S_RESULT) begin
            // Counts every working cycle; frozen while the result is held.
            cyc_d = sat_inc(cyc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift1_q <= '0;
            shift2_q <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            shift1_q <= shift1_d;
            shift2_q <= shift2_d;
            cyc_q    <= cyc_d;
        end
    end

    mnist_argmax_seq #(
        .OUT_DIM (OUT_DIM)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .start    (arg_start),
        .done     (arg_done),
        .addr     (logit_addr),
        .data     (logit_data),
        .best_idx (best_idx),
        .best_val (best_val)
    );

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign fc1_start  = (state_q == S_FC1_GO);
    assign fc2_start  = (state_q == S_FC2_GO);
    assign fc1_shift  = shift1_q;
    assign fc2_shift  = shift2_q;
    assign res_valid  = (state_q == S_RESULT);
    assign res_cycles = cyc_q;
    // Argmax registers are untouched once the scan ends, so the payload is
    // stable for as long as the result is held.
    assign res_class  = res_err ? CLASS_ERR : 4'(best_idx);
    assign res_score  = res_err ? '0 : best_val;

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// tb_mnist_infer_ctrl
// Self-checking bench for mnist_infer_ctrl: directed and randomized images
// compared against a behavioural argmax/latency model.
module tb_mnist_infer_ctrl;

    localparam int OUT_DIM = 10;
    localparam int WDOG    = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        cfg_shift1;
    logic [5:0]        cfg_shift2;
    logic              fc1_start;
    logic              fc1_done;
    logic [5:0]        fc1_shift;
    logic              fc2_start;
    logic              fc2_done;
    logic [5:0]        fc2_shift;
    logic [3:0]        logit_addr;
    logic signed [7:0] logit_data = '0;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_class;
    logic signed [7:0] res_score;
    logic              res_err;
    logic [23:0]       res_cycles;
    logic              busy;

    logic signed [7:0] mem [OUT_DIM];
    longint            cyc = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    int                img_no = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logit_data <= mem[logit_addr];
        cyc        <= cyc + 1;
    end

    mnist_infer_ctrl #(
        .HID_DIM     (32),
        .OUT_DIM     (OUT_DIM),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_shift1 (cfg_shift1),
        .cfg_shift2 (cfg_shift2),
        .fc1_start  (fc1_start),
        .fc1_done   (fc1_done),
        .fc1_shift  (fc1_shift),
        .fc2_start  (fc2_start),
        .fc2_done   (fc2_done),
        .fc2_shift  (fc2_shift),
        .logit_addr (logit_addr),
        .logit_data (logit_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
        .res_score  (res_score),
        .res_err    (res_err),
        .res_cycles (res_cycles),
        .busy       (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference argmax: first maximum in index order wins.
    task automatic ref_argmax(output int cls, output int scr);
        cls = 0;
        scr = int'(mem[0]);
        for (int i = 1; i < OUT_DIM; i++) begin
            if (int'(mem[i]) > scr) begin
                cls = i;
                scr = int'(mem[i]);
            end
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_in_ready"}, int'(in_ready), 1);
        chk({pfx, "_busy"}, int'(busy), 0);
        chk({pfx, "_starts"}, int'({fc1_start, fc2_start}), 0);
        chk({pfx, "_shifts"}, int'({fc1_shift, fc2_shift}), 0);
        chk({pfx, "_addr"}, int'(logit_addr), 0);
        chk({pfx, "_res_valid"}, int'(res_valid), 0);
        chk({pfx, "_res_payload"}, int'({res_class, res_score, res_err}), 0);
        chk({pfx, "_res_cycles"}, int'(res_cycles), 0);
    endtask

    task automatic run_image(input int s1, input int s2, input int new_s1,
                             input int d1, input int d2, input int hold,
                             input bit spurious);
        int     cls, scr, n;
        longint a_cyc, v_cyc;
        bit     ok;
        res_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 100) begin step(); n++; end
        chk("in_ready_before_accept", int'(in_ready), 1);
        cfg_shift1 = 6'(s1);
        cfg_shift2 = 6'(s2);
        in_valid   = 1'b1;
        a_cyc      = cyc;
        step();
        in_valid = 1'b0;
        chk("fc1_start_at_A1", int'(fc1_start), 1);
        chk("fc1_shift_latched", int'(fc1_shift), s1);
        chk("fc2_shift_latched", int'(fc2_shift), s2);
        chk("busy_after_accept", int'({busy, in_ready}), 2);
        cfg_shift1 = 6'(new_s1);
        cfg_shift2 = 6'($urandom_range(0, 63));
        for (int i = 0; i < d1; i++) begin
            step();
            fc2_done = spurious && (i == 0);
        end
        fc2_done = 1'b0;
        chk("fc1_start_in_wait", int'(fc1_start), 0);
        fc1_done = 1'b1;
        step();
        fc1_done = 1'b0;
        chk("fc2_start_at_D1p1", int'(fc2_start), 1);
        chk("fc1_shift_held", int'(fc1_shift), s1);
        for (int i = 0; i < d2; i++) step();
        fc2_done = 1'b1;
        step();
        fc2_done = 1'b0;
        n = 1;
        while (!res_valid && n < 100) begin step(); n++; end
        chk("res_latency", n, 12);
        v_cyc = cyc;
        ref_argmax(cls, scr);
        chk("res_class", int'(res_class), cls);
        chk("res_score", int'(res_score), scr);
        chk("res_err", int'(res_err), 0);
        chk("res_cycles", int'(res_cycles), int'(v_cyc - a_cyc - 1));
        $display("image %0d: class %0d score %0d cycles %0d (ref class %0d score %0d)",
                 img_no, res_class, res_score, res_cycles, cls, scr);
        img_no++;
        if (hold > 0) begin
            ok = 1'b1;
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                if (!res_valid || in_ready || int'(res_class) != cls ||
                    int'(res_score) != scr || longint'(res_cycles) != v_cyc - a_cyc - 1)
                    ok = 1'b0;
            end
            in_valid  = 1'b0;
            res_ready = 1'b1;
            chk("hold_stable", int'(ok), 1);
        end
        step();
        chk("res_valid_after_hs", int'(res_valid), 0);
        chk("in_ready_after_hs", int'(in_ready), 1);
        res_ready = 1'b0;
    endtask

    initial begin
        int n;
        bit saw;
        rst = 1'b1; in_valid = 1'b0; cfg_shift1 = '0; cfg_shift2 = '0;
        fc1_done = 1'b0; fc2_done = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < OUT_DIM; i++) mem[i] = '0;
        repeat (3) step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // Tie between index 2 and 3 resolves to 2; shift changes mid-image ignored.
        mem[0] = 8'sd3; mem[1] = -8'sd5; mem[2] = 8'sd90; mem[3] = 8'sd90;
        for (int i = 4; i < OUT_DIM; i++) mem[i] = '0;
        run_image(7, 12, 3, 3, 2, 0, 1'b0);

        // All logits at the minimum -> index 0.
        for (int i = 0; i < OUT_DIM; i++) mem[i] = -8'sd128;
        run_image(1, 2, 9, 2, 1, 1, 1'b1);

        // Long backpressure on the result port.
        for (int i = 0; i < OUT_DIM; i++) mem[i] = 8'($urandom);
        run_image(5, 6, 0, 4, 4, 20, 1'b0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < OUT_DIM; i++)
                mem[i] = (k % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            run_image($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                      $urandom_range(2, 6), $urandom_range(1, 6), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)));
        end

        // Reset during FC2 wait aborts the image.
        in_valid = 1'b1; cfg_shift1 = 6'd11; cfg_shift2 = 6'd22;
        step();
        in_valid = 1'b0;
        step();
        fc1_done = 1'b1;
        step();
        fc1_done = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("midrst");
        fc2_done = 1'b1;
        step();
        fc2_done = 1'b0;
        repeat (14) step();
        chk("late_fc2_done_busy", int'(busy), 0);
        chk("late_fc2_done_res_valid", int'(res_valid), 0);
        $display("reset-abort: busy %0d res_valid %0d", busy, res_valid);

`ifdef MNIST_CTRL_WDOG_EN
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        saw = 1'b0;
        n = 0;
        while (!res_valid && n < 400) begin
            step();
            n++;
            if (fc2_start) saw = 1'b1;
        end
        chk("wdog_res_valid", int'(res_valid), 1);
        chk("wdog_res_err", int'(res_err), 1);
        chk("wdog_res_class", int'(res_class), 15);
        chk("wdog_res_score", int'(res_score), 0);
        chk("wdog_no_fc2_start", int'(saw), 0);
        $display("watchdog: err %0d class %0d after %0d cycles", res_err, res_class, n);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        fc1_done = 1'b1;
        step();
        fc1_done = 1'b0;
        step();
        chk("wdog_late_done_ignored", int'(busy), 0);
`else
        saw = 1'b0;
        n = 0;
        if (saw) n = 1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mnist_infer_ctrl.md
# mnist_infer_ctrl

Top-level inference sequencer for the MNIST int8 pipeline. It accepts one loaded image per request and runs the layers in order: it pulses the fc1 engine and waits for its done, then does the same for fc2. It then reads the 10 int8 logits serially, computes the argmax and presents class, score, error flag and cycle count on a valid/ready result port. It owns the per-layer requantisation shift values, latched per image, and holds the engines idle between images.

## Interface
Parameters:
- HID_DIM, 32: fc1 output width (informational; checked against engine config in the bench).
- OUT_DIM, 10: number of logits scanned by argmax.
- WDOG_CYCLES, 65535: per-layer timeout in cycles (used only with the watchdog macro).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high. The layer engines share this reset.
- in_valid  in  1  image buffer loaded, request inference.
- in_ready  out  1  controller idle and able to accept.
- cfg_shift1  in  6  fc1 right-shift, sampled on accept.
- cfg_shift2  in  6  fc2 right-shift, sampled on accept.
- fc1_start  out  1  one-cycle start pulse to fc1.
- fc1_done  in  1  one-cycle done pulse from fc1.
- fc1_shift  out  6  latched cfg_shift1, stable for the whole image.
- fc2_start  out  1  one-cycle start pulse to fc2.
- fc2_done  in  1  one-cycle done pulse from fc2.
- fc2_shift  out  6  latched cfg_shift2.
- logit_addr  out  $clog2(OUT_DIM)  logit memory read address (registered).
- logit_data  in  8 signed  logit read data, 1-cycle synchronous latency.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_class  out  4  argmax index; 4'hF on error.
- res_score  out  8 signed  winning logit; 0 on error.
- res_err  out  1  layer timeout occurred.
- res_cycles  out  24  cycles from accept to res_valid, saturating at 24'hFFFFFF.
- busy  out  1  high in every state except S_IDLE.

## Operation
- States and transitions:
  - S_IDLE → S_FC1_GO on accept.
  - S_FC1_GO → S_FC1_WAIT.
  - S_FC1_WAIT → S_FC2_GO on fc1_done.
  - S_FC2_GO → S_FC2_WAIT.
  - S_FC2_WAIT → S_ARG on fc2_done.
  - S_ARG → S_RESULT after OUT_DIM+1 cycles.
  - S_RESULT → S_IDLE on res_valid&&res_ready.
- Accept is in_valid&&in_ready. in_ready=1 only in S_IDLE. On accept, cfg_shift1/2 latch into fc1_shift/fc2_shift and res_cycles clears.
- fc1_start=1 only in S_FC1_GO; fc2_start=1 only in S_FC2_GO. A done pulse in any state other than the matching WAIT state is ignored.
- Argmax scan:
  - Entering S_ARG, logit_addr=0; it increments each cycle up to OUT_DIM-1, then holds.
  - On S_ARG cycle t (t=1..OUT_DIM), logit_data is logit[t-1]. Index 0 is loaded unconditionally as the running best.
  - A later index replaces the best only if strictly greater (signed compare), so ties resolve to the lowest index.
- res_cycles increments every cycle from S_FC1_GO through the cycle before S_RESULT entry. It is frozen in S_RESULT.
- res_class, res_score, res_err and res_cycles are stable while res_valid=1.

## Timing
- Reset values:
  - state=S_IDLE, in_ready=1, busy=0.
  - fc1_start=fc2_start=0, fc1_shift=fc2_shift=0, logit_addr=0.
  - res_valid=0, res_class=0, res_score=0, res_err=0, res_cycles=0.
- Reset mid-operation aborts the image immediately. No result is produced, and in_ready=1 on the first cycle after rst deasserts.
- Accept at cycle A: fc1_start=1 at A+1.
- fc1_done sampled at D1: fc2_start=1 at D1+1.
- fc2_done sampled at D2: S_ARG occupies D2+1..D2+OUT_DIM+1, and res_valid=1 at D2+OUT_DIM+2 (D2+12 for OUT_DIM=10).
- Handshake: res_valid held until res_ready. The handshake at cycle R gives in_ready=1 at R+1. A new accept is never taken in the same cycle as the result handshake.
- res_ready held high continuously: each result lasts exactly one cycle.

## Configuration
- MNIST_CTRL_WDOG_EN defined:
  - A 16-bit counter clears on entry to each WAIT state. If it reaches WDOG_CYCLES without the matching done, the controller goes to S_RESULT with res_err=1, res_class=4'hF and res_score=0, skipping the remaining layers and argmax.
  - A late done arriving after the timeout is ignored.
- MNIST_CTRL_WDOG_EN undefined: the WAIT states wait indefinitely, res_err is tied 0, and no counter logic is generated.

## Structure
- Shared package mnist_pkg:
  - state enum encoding, 4 bits.
  - OUT_DIM/HID_DIM defaults, SHIFT_W=6, LOGIT_W=8, CLASS_ERR=4'hF.
- Sub-module mnist_argmax_seq: serial address generator plus compare/hold. Ports: start, done, addr, data, best_idx, best_val. The controller instantiates one.

## Test plan
- Logits [3,-5,90,90,0,0,0,0,0,0] → res_class=2, res_score=90; res_valid at fc2_done+12.
- All logits -128 → res_class=0, res_score=-128.
- cfg_shift1=7 at accept, then changed to 3 during S_FC1_WAIT → fc1_shift stays 7 until the next accept.
- res_ready low for 20 cycles → res_valid and outputs held, in_ready=0, in_valid ignored; res_ready=1 → in_ready=1 next cycle.
- rst pulsed during S_FC2_WAIT → all outputs at reset values, in_ready=1 next cycle, late fc2_done ignored.
- MNIST_CTRL_WDOG_EN with WDOG_CYCLES=100 and fc1_done never asserted → res_valid with res_err=1, res_class=15, fc2_start never pulsed.
